mips_writeback_stage: RTL and testbench

MEM/WB boundary and write-back stage of the MIPS pipeline; the direct upstream feeder of the register file write port.
- Accepts retired instructions from the MEM stage over a valid/ready handshake.
- Waits for load data where needed, then extracts and sign- or zero-extends byte, half or word.
- Drives a single-cycle registered write (rf_wen/rf_wa/rf_wd) into the register file; writes to register 0 are suppressed.

---
 rtl/mips_writeback_stage.sv | 186 ++++++++++++++++++
 tb/tb_mips_writeback_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_writeback_stage.sv
// mips_writeback_stage: MEM/WB boundary and write-back stage.
//   Accepts retired instructions from MEM over a valid/ready handshake, waits
//   for load data when needed, formats it (LW/LH/LHU/LB/LBU), and issues a
//   single-cycle registered write into the register file. Writes to r0 are
//   suppressed.
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready - MEM-stage handshake (in_ready combinational from state)
//   in_reg_write, in_mem_to_reg, in_wa, in_alu_result, in_load_type
//                     - retired instruction payload
//   mem_rvalid, mem_rdata - load data return (aligned 32-bit word)
//   wb_flush          - kill pending/incoming instruction
//   rf_wen, rf_wa, rf_wd  - registered register-file write port
//   wb_busy           - high while waiting for load data
// Optional: define MIPS_WB_FWD_EN to add fwd_valid/fwd_wa/fwd_wd bypass outputs.

module mips_writeback_stage #(
  parameter int unsigned AWL = 5,
  parameter int unsigned DWL = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_reg_write,
  input  logic           in_mem_to_reg,
  input  logic [AWL-1:0] in_wa,
  input  logic [DWL-1:0] in_alu_result,
  input  logic [2:0]     in_load_type,
  input  logic           mem_rvalid,
  input  logic [DWL-1:0] mem_rdata,
  input  logic           wb_flush,
  output logic           rf_wen,
  output logic [AWL-1:0] rf_wa,
  output logic [DWL-1:0] rf_wd,
  output logic           wb_busy
`ifdef MIPS_WB_FWD_EN
  ,
  output logic           fwd_valid,
  output logic [AWL-1:0] fwd_wa,
  output logic [DWL-1:0] fwd_wd
`endif
);

  // Load formatting slices assume a 32-bit datapath.
  if (DWL != 32) begin : g_bad_dwl
    $error("mips_writeback_stage: only DWL == 32 is supported");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } state_t;

  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  state_t           state_q, state_d;
  logic [AWL-1:0]   wa_q, wa_d;
  logic             reg_write_q, reg_write_d;
  logic [2:0]       load_type_q, load_type_d;
  logic [1:0]       off_q, off_d;
  logic             rf_wen_q, rf_wen_d;
  logic [AWL-1:0]   rf_wa_q, rf_wa_d;
  logic [DWL-1:0]   rf_wd_q, rf_wd_d;
  logic             accept;
  logic [DWL-1:0]   load_data;

  // Little-endian extraction and extension of the addressed byte/halfword.
  function automatic logic [DWL-1:0] fmt_load(input logic [2:0]     lt,
                                              input logic [1:0]     off,
                                              input logic [DWL-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (lt)
      LT_LH:   fmt_load = {{16{h[15]}}, h};
      LT_LHU:  fmt_load = {16'h0000, h};
      LT_LB:   fmt_load = {{24{b[7]}}, b};
      LT_LBU:  fmt_load = {24'h000000, b};
      default: fmt_load = w;
    endcase
  endfunction

  assign in_ready  = (state_q != WAIT_LOAD);
  assign wb_busy   = (state_q == WAIT_LOAD);
  assign accept    = in_valid & in_ready & ~wb_flush;
  assign load_data = fmt_load(load_type_q, off_q, mem_rdata);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    wa_d        = wa_q;
    reg_write_d = reg_write_q;
    load_type_d = load_type_q;
    off_d       = off_q;
    rf_wen_d    = 1'b0;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;

    case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (accept) begin
          wa_d        = in_wa;
          reg_write_d = in_reg_write;
          load_type_d = in_load_type;
          off_d       = in_alu_result[1:0];
          if (in_mem_to_reg) begin
            state_d = WAIT_LOAD;
          end else if (in_reg_write) begin
            state_d = WRITE;
            // r0 writes still pass through WRITE but never assert rf_wen.
            if (in_wa != '0) begin
              rf_wen_d = 1'b1;
              rf_wa_d  = in_wa;
              rf_wd_d  = in_alu_result;
            end
          end
        end
      end
      WAIT_LOAD: begin
        // Flush takes priority over a same-cycle data return.
        if (wb_flush) begin
          state_d = IDLE;
        end else if (mem_rvalid) begin
          if (reg_write_q) begin
            state_d = WRITE;
            if (wa_q != '0) begin
              rf_wen_d = 1'b1;
              rf_wa_d  = wa_q;
              rf_wd_d  = load_data;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wa_q        <= '0;
      reg_write_q <= 1'b0;
      load_type_q <= '0;
      off_q       <= '0;
      rf_wen_q    <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
    end else begin
      state_q     <= state_d;
      wa_q        <= wa_d;
      reg_write_q <= reg_write_d;
      load_type_q <= load_type_d;
      off_q       <= off_d;
      rf_wen_q    <= rf_wen_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
    end
  end

  assign rf_wen = rf_wen_q;
  assign rf_wa  = rf_wa_q;
  assign rf_wd  = rf_wd_q;

`ifdef MIPS_WB_FWD_EN
  // Bypass for a write that lands in the register file only at cycle end.
  assign fwd_valid = (state_q == WRITE) & reg_write_q & (wa_q != '0);
  assign fwd_wa    = rf_wa_q;
  assign fwd_wd    = rf_wd_q;
`endif

endmodule

// File: tb/tb_mips_writeback_stage.sv
module tb_mips_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [4:0]  in_wa;
  logic [31:0] in_alu_result;
  logic [2:0]  in_load_type;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_flush;
  logic        rf_wen;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        wb_busy;
`ifdef MIPS_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_wa;
  logic [31:0] fwd_wd;
`endif

  mips_writeback_stage #(.AWL(5), .DWL(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_wa         (in_wa),
    .in_alu_result (in_alu_result),
    .in_load_type  (in_load_type),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .wb_flush      (wb_flush),
    .rf_wen        (rf_wen),
    .rf_wa         (rf_wa),
    .rf_wd         (rf_wd),
    .wb_busy       (wb_busy)
`ifdef MIPS_WB_FWD_EN
    ,
    .fwd_valid     (fwd_valid),
    .fwd_wa        (fwd_wa),
    .fwd_wd        (fwd_wd)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare any register-file write to the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_wen", 32'(rf_wen), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_wa", 32'(rf_wa), 32'(e.wa));
        chk("wb_wd", rf_wd, e.wd);
`ifdef MIPS_WB_FWD_EN
        chk("fwd_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_wa", 32'(fwd_wa), 32'(e.wa));
        chk("fwd_wd", fwd_wd, e.wd);
`endif
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_reg_write  = 1'b0;
    in_mem_to_reg = 1'b0;
    in_wa         = '0;
    in_alu_result = '0;
    in_load_type  = '0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    wb_flush      = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] wa, input logic [31:0] val, input logic rw);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_mem_to_reg = 1'b0;
    in_wa         = wa;
    in_alu_result = val;
    if (rw && wa != 5'd0) exp_q.push_back('{wa: wa, wd: val});
  endtask

  task automatic drive_load(input logic [4:0] wa, input logic [2:0] lt,
                            input logic [31:0] addr, input logic rw);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_mem_to_reg = 1'b1;
    in_wa         = wa;
    in_alu_result = addr;
    in_load_type  = lt;
  endtask

  // Full load: accept, wait a few cycles, return data, expect formatted write.
  task automatic do_load(input string tag, input logic [4:0] wa, input logic [2:0] lt,
                         input logic [31:0] addr, input logic [31:0] word,
                         input logic [31:0] exp_wd, input int waitc);
    drive_load(wa, lt, addr, 1'b1);
    tick();
    idle_inputs();
    for (int i = 0; i < waitc; i++) begin
      chk({tag, "_ready_wait"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy_wait"}, 32'(wb_busy), 32'd1);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    exp_q.push_back('{wa: wa, wd: exp_wd});
    tick();
    chk({tag, "_wen"}, 32'(rf_wen), 32'd1);
    mem_rvalid = 1'b0;
    tick();
    chk({tag, "_wen_drop"}, 32'(rf_wen), 32'd0);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_wa", 32'(rf_wa), 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(wb_busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single ALU write.
    drive_alu(5'd5, 32'h0000_00AA, 1'b1);
    tick();
    chk("alu_wen", 32'(rf_wen), 32'd1);
    idle_inputs();
    tick();
    chk("alu_wen_drop", 32'(rf_wen), 32'd0);

    // mem_rvalid outside a pending load must not write.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    chk("stray_rvalid_wen", 32'(rf_wen), 32'd0);
    idle_inputs();

    // Load formatting.
    do_load("lb",  5'd7,  3'd3, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 2);
    do_load("lhu", 5'd8,  3'd2, 32'h0000_2002, 32'h9ABC_5678, 32'h0000_9ABC, 1);
    do_load("lh",  5'd9,  3'd1, 32'h0000_2002, 32'h9ABC_5678, 32'hFFFF_9ABC, 0);
    do_load("lh0", 5'd10, 3'd1, 32'h0000_2000, 32'h9ABC_8678, 32'hFFFF_8678, 1);
    do_load("lbu", 5'd11, 3'd4, 32'h0000_3001, 32'h80FF_1234, 32'h0000_0012, 1);
    do_load("lb2", 5'd12, 3'd3, 32'h0000_3002, 32'h80FF_1234, 32'hFFFF_FFFF, 1);
    do_load("lw",  5'd13, 3'd0, 32'h0000_4003, 32'h1357_9BDF, 32'h1357_9BDF, 1);
    do_load("lt7", 5'd14, 3'd7, 32'h0000_4001, 32'h2468_ACE0, 32'h2468_ACE0, 1);

    // Load with reg_write clear: consumed, no write.
    drive_load(5'd15, 3'd0, 32'h0, 1'b0);
    tick();
    idle_inputs();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    tick();
    chk("load_norw_wen", 32'(rf_wen), 32'd0);
    chk("load_norw_ready", 32'(in_ready), 32'd1);
    idle_inputs();

    // Back-to-back ALU ops to r1, r2, r0.
    drive_alu(5'd1, 32'h0000_0101, 1'b1);
    tick();
    chk("b2b_wen1", 32'(rf_wen), 32'd1);
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    drive_alu(5'd2, 32'h0000_0202, 1'b1);
    tick();
    chk("b2b_wen2", 32'(rf_wen), 32'd1);
    chk("b2b_ready2", 32'(in_ready), 32'd1);
    drive_alu(5'd0, 32'h0000_0303, 1'b1);
    tick();
    chk("b2b_wen0", 32'(rf_wen), 32'd0);
    chk("b2b_ready0", 32'(in_ready), 32'd1);
    idle_inputs();
    tick();
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Store/branch (no reg_write) is consumed without a write.
    drive_alu(5'd3, 32'h0000_0333, 1'b0);
    tick();
    chk("store_wen", 32'(rf_wen), 32'd0);
    idle_inputs();

    // Flush in IDLE blocks the accept.
    drive_alu(5'd4, 32'h0000_0444, 1'b0);
    in_reg_write = 1'b1;
    wb_flush     = 1'b1;
    tick();
    chk("flush_idle_wen", 32'(rf_wen), 32'd0);
    idle_inputs();

    // Flush during WRITE: current write completes, incoming op dropped.
    drive_alu(5'd6, 32'h0000_0666, 1'b1);
    tick();
    chk("flush_wr_wen", 32'(rf_wen), 32'd1);
    in_wa         = 5'd17;
    in_alu_result = 32'h0000_0777;
    wb_flush      = 1'b1;
    tick();
    chk("flush_wr_blocked", 32'(rf_wen), 32'd0);
    idle_inputs();

    // Flush wins over same-cycle mem_rvalid.
    drive_load(5'd18, 3'd0, 32'h0, 1'b1);
    tick();
    idle_inputs();
    chk("flush_ld_busy", 32'(wb_busy), 32'd1);
    wb_flush   = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    chk("flush_ld_wen", 32'(rf_wen), 32'd0);
    chk("flush_ld_ready", 32'(in_ready), 32'd1);
    idle_inputs();
    mem_rvalid = 1'b1;
    tick();
    chk("flush_ld_late_wen", 32'(rf_wen), 32'd0);
    idle_inputs();

    // Reset mid-wait drops the pending load.
    drive_alu(5'd20, 32'h0000_5A5A, 1'b1);
    tick();
    chk("pre_rst_wen", 32'(rf_wen), 32'd1);
    drive_load(5'd21, 3'd0, 32'h0, 1'b1);
    in_mem_to_reg = 1'b1;
    tick();
    idle_inputs();
    chk("pre_rst_busy", 32'(wb_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", 32'(wb_busy), 32'd0);
    tick();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    tick();
    chk("rst_mid_wen", 32'(rf_wen), 32'd0);
    chk("rst_mid_wa", 32'(rf_wa), 32'd0);
    chk("rst_mid_wd", rf_wd, 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    idle_inputs();
    tick();
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
